// File: rtl/ksa2_pkg.sv
// Shared types and sizing helpers for the KSA2 digit-serial controller.
package ksa2_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Default KSA2 pulse latency from operand input to sum/cout.
    localparam int unsigned KSA2_PIPE_LAT = 4;

    // Number of 2-bit digits in a word.
    function automatic int unsigned ndig(input int unsigned word_w);
        return word_w / 2;
    endfunction

    // Counter width able to hold values 0..n-1 (at least one bit).
    function automatic int unsigned idx_w(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ksa2_serial_ctrl_if.sv
// Operand request / result handshake bundle for ksa2_serial_ctrl.
interface ksa2_serial_ctrl_if #(
    parameter int unsigned WORD_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              cin;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] sum;
    logic              cout;

    modport master (
        output in_valid, a, b, cin, out_ready,
        input  in_ready, out_valid, sum, cout
    );

    modport slave (
        input  in_valid, a, b, cin, out_ready,
        output in_ready, out_valid, sum, cout
    );
endinterface

// File: rtl/ksa2_digit_shreg.sv
// Sum digit capture register and inter-digit carry register.
module ksa2_digit_shreg
    import ksa2_pkg::*;
#(
    parameter  int unsigned WORD_W = 8,
    localparam int unsigned IDX_W  = idx_w(ndig(WORD_W))
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              cap,
    input  logic [IDX_W-1:0]  idx,
    input  logic [1:0]        digit,
    input  logic              carry_d,
    output logic [WORD_W-1:0] sum,
    output logic              carry
);

    // Clear on word acceptance; capture one digit and its carry per KSA2 result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (clr) begin
            sum   <= '0;
            carry <= 1'b0;
        end else if (cap) begin
            sum[{idx, 1'b0} +: 2] <= digit;
            carry                 <= carry_d;
        end
    end

endmodule

// File: rtl/ksa2_serial_ctrl.sv
// Digit-serial word adder controller driving an external 2-bit KSA2.
// Optional feature: define KSA2_SELFCHECK_EN to add a behavioural reference
// adder that sets the sticky err flag on a result mismatch.
module ksa2_serial_ctrl
    import ksa2_pkg::*;
#(
    parameter int unsigned WORD_W   = 8,
    parameter int unsigned PIPE_LAT = KSA2_PIPE_LAT
) (
    input  logic               GCLK_Pad,
    input  logic               rst_n_Pad,
    ksa2_serial_ctrl_if.slave  bus,
    output logic [1:0]         ksa_a,
    output logic [1:0]         ksa_b,
    output logic               ksa_cin,
    input  logic [1:0]         ksa_sum,
    input  logic               ksa_cout,
    output logic               err
);

    localparam int unsigned NDIG  = ndig(WORD_W);
    localparam int unsigned IDX_W = idx_w(NDIG);
    localparam int unsigned CNT_W = idx_w(PIPE_LAT + 1);

    state_e            state, state_nxt;
    logic [IDX_W-1:0]  k_q, k_nxt, k_inc;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [WORD_W-1:0] a_q, b_q;
    logic              accept, cap;
    logic [1:0]        ksa_a_nxt, ksa_b_nxt;
    logic              ksa_cin_nxt;
    logic              in_ready_q, out_valid_q;
    logic [WORD_W-1:0] sum_w;
    logic              carry_w;

    assign k_inc = k_q + IDX_W'(1);

    // Next-state, counters and the pulse values to present during ISSUE.
    always_comb begin
        state_nxt   = state;
        k_nxt       = k_q;
        cnt_nxt     = cnt_q;
        accept      = 1'b0;
        cap         = 1'b0;
        ksa_a_nxt   = 2'b00;
        ksa_b_nxt   = 2'b00;
        ksa_cin_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (bus.in_valid) begin
                    accept      = 1'b1;
                    k_nxt       = '0;
                    state_nxt   = ISSUE;
                    ksa_a_nxt   = bus.a[1:0];
                    ksa_b_nxt   = bus.b[1:0];
                    ksa_cin_nxt = bus.cin;
                end
            end
            ISSUE: begin
                cnt_nxt   = CNT_W'(1);
                state_nxt = WAIT;
            end
            WAIT: begin
                if (cnt_q == CNT_W'(PIPE_LAT)) begin
                    cap     = 1'b1;
                    cnt_nxt = '0;
                    if (k_q == IDX_W'(NDIG - 1)) begin
                        state_nxt = DONE;
                    end else begin
                        k_nxt       = k_inc;
                        state_nxt   = ISSUE;
                        ksa_a_nxt   = a_q[{k_inc, 1'b0} +: 2];
                        ksa_b_nxt   = b_q[{k_inc, 1'b0} +: 2];
                        ksa_cin_nxt = ksa_cout;
                    end
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // State, counters, operand latches and registered handshake/KSA2 outputs.
    always_ff @(posedge GCLK_Pad or negedge rst_n_Pad) begin
        if (!rst_n_Pad) begin
            state       <= IDLE;
            k_q         <= '0;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            ksa_a       <= 2'b00;
            ksa_b       <= 2'b00;
            ksa_cin     <= 1'b0;
        end else begin
            state       <= state_nxt;
            k_q         <= k_nxt;
            cnt_q       <= cnt_nxt;
            in_ready_q  <= (state_nxt == IDLE);
            out_valid_q <= (state_nxt == DONE);
            ksa_a       <= ksa_a_nxt;
            ksa_b       <= ksa_b_nxt;
            ksa_cin     <= ksa_cin_nxt;
            if (accept) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
        end
    end

    ksa2_digit_shreg #(
        .WORD_W (WORD_W)
    ) u_shreg (
        .clk     (GCLK_Pad),
        .rst_n   (rst_n_Pad),
        .clr     (accept),
        .cap     (cap),
        .idx     (k_q),
        .digit   (ksa_sum),
        .carry_d (ksa_cout),
        .sum     (sum_w),
        .carry   (carry_w)
    );

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.sum       = sum_w;
    assign bus.cout      = carry_w;

`ifdef KSA2_SELFCHECK_EN
    localparam int unsigned REF_W = WORD_W + 1;

    logic [REF_W-1:0] ref_q;
    logic             chk_q;
    logic             err_q;

    // Reference sum taken at acceptance, compared in the first DONE cycle.
    always_ff @(posedge GCLK_Pad or negedge rst_n_Pad) begin
        if (!rst_n_Pad) begin
            ref_q <= '0;
            chk_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            chk_q <= (state_nxt == DONE) && (state != DONE);
            if (accept) begin
                ref_q <= REF_W'(bus.a) + REF_W'(bus.b) + REF_W'(bus.cin);
            end
            if (chk_q && ({carry_w, sum_w} != ref_q)) begin
                err_q <= 1'b1;
            end
        end
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_ksa2_serial_ctrl.sv
// Directed bench for ksa2_serial_ctrl with a behavioural KSA2 pipeline model.
// Build with KSA2_SELFCHECK_EN defined to also exercise the sticky err path.
module tb_ksa2_serial_ctrl;

    localparam int unsigned WORD_W   = 8;
    localparam int unsigned PIPE_LAT = 4;
    localparam int unsigned LAT_EXP  = 21;

    logic       clk;
    logic       rst_n;
    logic [1:0] ksa_a, ksa_b, ksa_sum;
    logic       ksa_cin, ksa_cout, err;
    logic       flip_now;
    logic       err_exp;

    int n_assert;
    int n_fail;

    logic [2:0] pipe [PIPE_LAT];

    ksa2_serial_ctrl_if #(.WORD_W(WORD_W)) bus ();

    ksa2_serial_ctrl #(
        .WORD_W   (WORD_W),
        .PIPE_LAT (PIPE_LAT)
    ) dut (
        .GCLK_Pad  (clk),
        .rst_n_Pad (rst_n),
        .bus       (bus),
        .ksa_a     (ksa_a),
        .ksa_b     (ksa_b),
        .ksa_cin   (ksa_cin),
        .ksa_sum   (ksa_sum),
        .ksa_cout  (ksa_cout),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // KSA2 model: PIPE_LAT-deep pipeline of {cout,sum}, optional sum[1] flip.
    always @(posedge clk) begin
        pipe[0] <= (3'(ksa_a) + 3'(ksa_b) + 3'(ksa_cin)) ^ (flip_now ? 3'b010 : 3'b000);
        for (int i = 1; i < PIPE_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign ksa_sum  = pipe[PIPE_LAT-1][1:0];
    assign ksa_cout = pipe[PIPE_LAT-1][2];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // One word: handshake, timing, per-digit KSA2 drive, optional DONE hold, drain.
    task automatic run_word(input logic [7:0] a, input logic [7:0] b, input logic cin,
                            input logic [7:0] exp_sum, input logic exp_cout,
                            input logic [3:0] exp_cins, input int hold, input logic flip);
        int         lat;
        int         viol;
        logic       got;
        logic [1:0] rec_a [4];
        logic [1:0] rec_b [4];
        logic [3:0] rec_cin;
        int         k;
        rec_cin = '0;
        for (int i = 0; i < 4; i++) begin
            rec_a[i] = 2'bxx;
            rec_b[i] = 2'bxx;
        end
        @(negedge clk);
        chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
        bus.a = a;
        bus.b = b;
        bus.cin = cin;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        flip_now = flip;
        lat = 0;
        viol = 0;
        got = 1'b0;
        while (!got && lat < 60) begin
            @(negedge clk);
            lat++;
            if (lat == 2) flip_now = 1'b0;
            if (bus.out_valid) begin
                got = 1'b1;
            end else if (((lat - 1) % 5 == 0) && ((lat - 1) / 5 < 4)) begin
                k = (lat - 1) / 5;
                rec_a[k] = ksa_a;
                rec_b[k] = ksa_b;
                rec_cin[k] = ksa_cin;
            end else if ((ksa_a != 2'b00) || (ksa_b != 2'b00) || ksa_cin) begin
                viol++;
            end
        end
        chk("latency", 32'(lat), 32'(LAT_EXP));
        chk("sum", 32'(bus.sum), 32'(exp_sum));
        chk("cout", 32'(bus.cout), 32'(exp_cout));
        chk("in_ready_done", 32'(bus.in_ready), 32'd0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("ksa_a_d%0d", i), 32'(rec_a[i]), 32'(a[2*i +: 2]));
            chk($sformatf("ksa_b_d%0d", i), 32'(rec_b[i]), 32'(b[2*i +: 2]));
        end
        chk("ksa_cin_digits", 32'(rec_cin), 32'(exp_cins));
        chk("ksa_idle_zero", 32'(viol), 32'd0);
        for (int i = 0; i < hold; i++) begin
            bus.in_valid = i[0];
            bus.a = 8'h11;
            @(negedge clk);
            chk("hold_out_valid", 32'(bus.out_valid), 32'd1);
            chk("hold_in_ready", 32'(bus.in_ready), 32'd0);
            chk("hold_sum", 32'(bus.sum), 32'(exp_sum));
            chk("hold_cout", 32'(bus.cout), 32'(exp_cout));
        end
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("drain_out_valid", 32'(bus.out_valid), 32'd0);
        chk("drain_in_ready", 32'(bus.in_ready), 32'd1);
        chk("err", 32'(err), 32'(err_exp));
    endtask

    initial begin
        n_assert = 0;
        n_fail = 0;
        flip_now = 1'b0;
        err_exp = 1'b0;
        rst_n = 1'b0;
        bus.in_valid = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.cin = 1'b0;
        bus.out_ready = 1'b0;
        #3;
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_sum", 32'(bus.sum), 32'd0);
        chk("rst_cout", 32'(bus.cout), 32'd0);
        chk("rst_ksa", 32'({ksa_a, ksa_b, ksa_cin}), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_in_ready", 32'(bus.in_ready), 32'd1);

        run_word(8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 4'b0000, 0, 1'b0);
        run_word(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 4'b1110, 0, 1'b0);
        run_word(8'h37, 8'h2C, 1'b0, 8'h63, 1'b0, 4'b1100, 10, 1'b0);
        run_word(8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1, 4'b1111, 0, 1'b0);

        // Reset during WAIT of digit 2 (ISSUE of digit 2 is cycle T+11).
        @(negedge clk);
        bus.a = 8'h12;
        bus.b = 8'h34;
        bus.cin = 1'b0;
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (13) @(negedge clk);
        chk("pre_rst_partial_sum", 32'(bus.sum), 32'h06);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ksa", 32'({ksa_a, ksa_b, ksa_cin}), 32'd0);
        chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_sum", 32'(bus.sum), 32'd0);
        chk("mid_rst_cout", 32'(bus.cout), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("post_rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("post_rst_out_valid", 32'(bus.out_valid), 32'd0);
        run_word(8'h80, 8'h80, 1'b1, 8'h01, 1'b1, 4'b0001, 0, 1'b0);

`ifdef KSA2_SELFCHECK_EN
        // Corrupted digit 0 result: sum reads 0x02, err latches and stays.
        err_exp = 1'b1;
        run_word(8'h00, 8'h00, 1'b0, 8'h02, 1'b0, 4'b0000, 0, 1'b1);
        run_word(8'h37, 8'h2C, 1'b0, 8'h63, 1'b0, 4'b1100, 0, 1'b0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
